fft_add_feeder: RTL and testbench

FFT_ADD_FEEDER -- requirements
Module: fft_add_feeder

---
 rtl/fft_add_feeder.sv | 128 ++++++++++++
 tb/tb_fft_add_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_add_feeder.sv
// Pairs a serial float stream into A/B operands for a float adder, through a 4-deep pair FIFO.
// Define FFT_FEEDER_SUB_EN to honour s_axis_op_tuser as a subtract flag (B sign flip).
module fft_add_feeder (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_op_tvalid,
  output logic        s_axis_op_tready,
  input  logic [31:0] s_axis_op_tdata,
  input  logic        s_axis_op_tuser,
  input  logic        flush,
  output logic        m_axis_a_tvalid,
  input  logic        m_axis_a_tready,
  output logic [31:0] m_axis_a_tdata,
  output logic        m_axis_b_tvalid,
  input  logic        m_axis_b_tready,
  output logic [31:0] m_axis_b_tdata,
  output logic [2:0]  fifo_level
);

  localparam int DEPTH = 4;

  typedef enum logic {WAIT_A, WAIT_B} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hold;
  logic [31:0] r_mem_a [DEPTH];
  logic [31:0] r_mem_b [DEPTH];
`ifdef FFT_FEEDER_SUB_EN
  logic        r_mem_f [DEPTH];
`else
  logic        w_unused_tuser;
`endif
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_level;
  logic        r_a_done, r_b_done;
  logic        w_nempty, w_s_hs, w_push;
  logic        w_a_hs, w_b_hs, w_pop;
  logic [31:0] w_b_raw;

  assign w_nempty = (r_level != 3'd0);

  // No pass-through credit: a pop in this cycle does not open ready.
  assign s_axis_op_tready = aresetn && !flush &&
                            ((r_state == WAIT_A) || (r_level < 3'd4));
  assign w_s_hs = s_axis_op_tvalid && s_axis_op_tready;
  assign w_push = w_s_hs && (r_state == WAIT_B);

  assign m_axis_a_tvalid = w_nempty && !r_a_done;
  assign m_axis_b_tvalid = w_nempty && !r_b_done;
  assign w_a_hs = m_axis_a_tvalid && m_axis_a_tready;
  assign w_b_hs = m_axis_b_tvalid && m_axis_b_tready;
  assign w_pop  = w_nempty && (r_a_done || w_a_hs) &&
                  (r_b_done || w_b_hs);

  assign m_axis_a_tdata = w_nempty ? r_mem_a[r_rptr] : '0;
  assign w_b_raw        = w_nempty ? r_mem_b[r_rptr] : '0;

`ifdef FFT_FEEDER_SUB_EN
  assign m_axis_b_tdata = w_b_raw ^
    {(w_nempty && r_mem_f[r_rptr]), 31'd0};
`else
  assign m_axis_b_tdata = w_b_raw;
  assign w_unused_tuser = s_axis_op_tuser;
`endif

  assign fifo_level = r_level;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = WAIT_A;
    else if (w_s_hs)
      w_state_nxt = (r_state == WAIT_A) ? WAIT_B : WAIT_A;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_state <= WAIT_A;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hold   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
`ifdef FFT_FEEDER_SUB_EN
        r_mem_f[i] <= 1'b0;
`endif
      end
    end else if (flush) begin
      r_hold   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
    end else begin
      if (w_s_hs && (r_state == WAIT_A))
        r_hold <= s_axis_op_tdata;
      if (w_push) begin
        r_mem_a[r_wptr] <= r_hold;
        r_mem_b[r_wptr] <= s_axis_op_tdata;
`ifdef FFT_FEEDER_SUB_EN
        r_mem_f[r_wptr] <= s_axis_op_tuser;
`endif
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + 2'd1;
        r_a_done <= 1'b0;
        r_b_done <= 1'b0;
      end else begin
        if (w_a_hs) r_a_done <= 1'b1;
        if (w_b_hs) r_b_done <= 1'b1;
      end
      r_level <= r_level + {2'b0, w_push} - {2'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fft_add_feeder.sv
// Scoreboard bench for fft_add_feeder: driver queues expected A/B words,
// a negedge monitor checks every output handshake against them.
module tb_fft_add_feeder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        s_tuser = 1'b0;
  logic        flush = 1'b0;
  logic        a_tvalid, b_tvalid;
  logic        a_tready = 1'b0, b_tready = 1'b0;
  logic [31:0] a_tdata, b_tdata;
  logic [2:0]  level;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  fft_add_feeder dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_op_tvalid (s_tvalid),
    .s_axis_op_tready (s_tready),
    .s_axis_op_tdata  (s_tdata),
    .s_axis_op_tuser  (s_tuser),
    .flush            (flush),
    .m_axis_a_tvalid  (a_tvalid),
    .m_axis_a_tready  (a_tready),
    .m_axis_a_tdata   (a_tdata),
    .m_axis_b_tvalid  (b_tvalid),
    .m_axis_b_tready  (b_tready),
    .m_axis_b_tdata   (b_tdata),
    .fifo_level       (level)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (a_tvalid && a_tready) begin
        if (qa.size() == 0) chk("unexpected_A", a_tdata, 32'hxxxxxxxx);
        else chk("A_data", a_tdata, qa.pop_front());
      end
      if (b_tvalid && b_tready) begin
        if (qb.size() == 0) chk("unexpected_B", b_tdata, 32'hxxxxxxxx);
        else chk("B_data", b_tdata, qb.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge aclk); #1;
  endtask

  task automatic samp;
    @(negedge aclk);
  endtask

  task automatic send(input logic [31:0] d, input logic u);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u;
    samp();
    while (!s_tready && n < 50) begin
      n++;
      samp();
    end
    if (!s_tready) chk("send_timeout", {31'd0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic u);
    logic [31:0] eb;
    eb = b;
`ifdef FFT_FEEDER_SUB_EN
    if (u) eb = b ^ 32'h8000_0000;
`endif
    send(a, 1'b0);
    send(b, u);
    qa.push_back(a);
    qb.push_back(eb);
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    samp();
    while (level != 3'd0 && n < 50) begin
      n++;
      step();
      samp();
    end
    chk(nm, {29'd0, level}, 32'd0);
    step();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_lvl"}, {29'd0, level}, 32'd0);
    chk({nm, "_av"}, {31'd0, a_tvalid}, 32'd0);
    chk({nm, "_bv"}, {31'd0, b_tvalid}, 32'd0);
    chk({nm, "_ad"}, a_tdata, 32'd0);
    chk({nm, "_bd"}, b_tdata, 32'd0);
  endtask

  initial begin
    logic [31:0] eb;
    // reset state
    s_tvalid = 1'b1;
    repeat (3) step();
    samp();
    chk_idle("rst");
    chk("rst_srdy", {31'd0, s_tready}, 32'd0);
    step();
    s_tvalid = 1'b0;
    aresetn = 1'b1;
    samp();
    chk("rel_srdy", {31'd0, s_tready}, 32'd1);
    step();

    // basic pair, latency 1
    a_tready = 1'b1; b_tready = 1'b1;
    send_pair(32'h3F80_0000, 32'h4000_0000, 1'b0);
    samp();
    chk("lat_av", {31'd0, a_tvalid}, 32'd1);
    chk("lat_bv", {31'd0, b_tvalid}, 32'd1);
    chk("lat_lvl", {29'd0, level}, 32'd1);
    step();
    samp();
    chk("pop_lvl", {29'd0, level}, 32'd0);
    step();

    // saturation with both readies low
    a_tready = 1'b0; b_tready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_pair(32'h1000_0000 + i, 32'h2000_0000 + i, 1'b0);
    samp();
    chk("sat_lvl", {29'd0, level}, 32'd4);
    chk("sat_rdyA", {31'd0, s_tready}, 32'd1);
    step();
    send(32'h0000_0009, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'h0000_000A;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("stall_rdy", {31'd0, s_tready}, 32'd0);
      step();
    end
    s_tvalid = 1'b0;
    a_tready = 1'b1; b_tready = 1'b1;
    wait_empty("drain4");
    send(32'h0000_000A, 1'b0);
    qa.push_back(32'h0000_0009);
    qb.push_back(32'h0000_000A);
    wait_empty("drain9");

    // split acceptance, A first then B three cycles later
    a_tready = 1'b0; b_tready = 1'b0;
    send_pair(32'h1111_1111, 32'h2222_2222, 1'b0);
    a_tready = 1'b1;
    step();
    a_tready = 1'b0;
    samp();
    chk("split_av", {31'd0, a_tvalid}, 32'd0);
    chk("split_bv", {31'd0, b_tvalid}, 32'd1);
    chk("split_bd", b_tdata, 32'h2222_2222);
    step(); samp();
    chk("split_bv2", {31'd0, b_tvalid}, 32'd1);
    step();
    b_tready = 1'b1;
    step();
    b_tready = 1'b0;
    samp();
    chk("split_lvl", {29'd0, level}, 32'd0);
    chk("split_av2", {31'd0, a_tvalid}, 32'd0);
    step();

    // subtract flag
    send_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
`ifdef FFT_FEEDER_SUB_EN
    eb = 32'hC000_0000;
`else
    eb = 32'h4000_0000;
`endif
    samp();
    chk("sub_bd", b_tdata, eb);
    step();
    a_tready = 1'b1; b_tready = 1'b1;
    wait_empty("sub_drain");

    // flush with 2 pairs plus a pending A
    a_tready = 1'b0; b_tready = 1'b0;
    send_pair(32'h0A0A_0001, 32'h0B0B_0001, 1'b0);
    send_pair(32'h0A0A_0002, 32'h0B0B_0002, 1'b0);
    send(32'hDEAD_BEEF, 1'b0);
    samp();
    chk("pre_fl_lvl", {29'd0, level}, 32'd2);
    step();
    flush = 1'b1;
    s_tvalid = 1'b1; s_tdata = 32'hBAD0_BAD0;
    samp();
    chk("fl_srdy", {31'd0, s_tready}, 32'd0);
    step();
    flush = 1'b0; s_tvalid = 1'b0;
    qa.delete(); qb.delete();
    samp();
    chk("fl_lvl", {29'd0, level}, 32'd0);
    chk("fl_av", {31'd0, a_tvalid}, 32'd0);
    chk("fl_bv", {31'd0, b_tvalid}, 32'd0);
    step();
    a_tready = 1'b1; b_tready = 1'b1;
    send_pair(32'h5555_0000, 32'h6666_0000, 1'b0);
    wait_empty("fl_drain");

    // reset mid-transfer with 3 pairs plus a pending A
    a_tready = 1'b0; b_tready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_pair(32'h7000_0000 + i, 32'h8000_0000 + i, 1'b0);
    send(32'hCAFE_0000, 1'b0);
    samp();
    chk("pre_rst_lvl", {29'd0, level}, 32'd3);
    step();
    aresetn = 1'b0;
    samp();
    chk_idle("mid_rst");
    chk("mid_rst_srdy", {31'd0, s_tready}, 32'd0);
    qa.delete(); qb.delete();
    step();
    aresetn = 1'b1;
    a_tready = 1'b1; b_tready = 1'b1;
    send_pair(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_empty("rst_drain");

    chk("qa_left", qa.size(), 32'd0);
    chk("qb_left", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
